// File: rtl/img_pkg.sv
// Shared definitions for the image transform engine: mode encodings, FSM
// state constants and the helper that says whether a mode swaps width/height.
package img_pkg;

  typedef logic [2:0] mode_t;
  typedef logic [1:0] state_t;

  localparam mode_t MODE_IDENT   = 3'd0;
  localparam mode_t MODE_ROT_CCW = 3'd1;
  localparam mode_t MODE_ROT_CW  = 3'd2;
  localparam mode_t MODE_ROT180  = 3'd3;
  localparam mode_t MODE_MIRR_H  = 3'd4;
  localparam mode_t MODE_MIRR_V  = 3'd5;
  localparam mode_t MODE_TRANS   = 3'd6;
  localparam mode_t MODE_ATRANS  = 3'd7;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_LOAD = 2'd1;
  localparam state_t ST_READ = 2'd2;

  // Modes whose output frame is IMG_H wide and IMG_W tall.
  function automatic logic is_swap(input mode_t m);
    return (m == MODE_ROT_CCW) || (m == MODE_ROT_CW) ||
           (m == MODE_TRANS)   || (m == MODE_ATRANS);
  endfunction

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous SRAM with a registered read port (1-cycle latency).
// Contents are never reset.
module sram_sp #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Write on we, otherwise read into the output register.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/img_xform_engine.sv
// Frame-buffer transform engine: loads one IMG_W x IMG_H frame in raster
// order, then streams it out rotated/mirrored/transposed with valid/ready.
module img_xform_engine
  import img_pkg::*;
#(
  parameter int IMG_W  = 1024,
  parameter int IMG_H  = 1024,
  parameter int PIX_W  = 24,
  parameter int ADDR_W = $clog2(IMG_W * IMG_H),
  parameter int X_W    = $clog2((IMG_W > IMG_H) ? IMG_W : IMG_H),
  parameter int Y_W    = X_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cfg_mode,
  input  logic             cfg_reuse,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             done
);

  localparam logic [X_W-1:0]    W_LAST_X = X_W'(IMG_W - 1);
  localparam logic [X_W-1:0]    H_LAST_X = X_W'(IMG_H - 1);
  localparam logic [Y_W-1:0]    W_LAST_Y = Y_W'(IMG_W - 1);
  localparam logic [Y_W-1:0]    H_LAST_Y = Y_W'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);

  state_t           r_state;
  mode_t            r_mode;
  logic             r_frame_valid;
  logic             r_done;
  logic [X_W-1:0]   r_lx;
  logic [Y_W-1:0]   r_ly;
  logic [X_W-1:0]   r_ox;
  logic [Y_W-1:0]   r_oy;
  logic             r_iss_done;
  logic             r_pend;
  logic             r_pend_eol;
  logic             r_pend_eof;
  logic [PIX_W-1:0] r_buf_data [2];
  logic [1:0]       r_buf_eol;
  logic [1:0]       r_buf_eof;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_cnt;

  logic              w_swap;
  logic [X_W-1:0]    w_ox_last;
  logic [Y_W-1:0]    w_oy_last;
  logic [X_W-1:0]    w_sx;
  logic [Y_W-1:0]    w_sy;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [ADDR_W-1:0] w_addr;
  logic              w_start;
  logic              w_in_hs;
  logic              w_load_last;
  logic              w_pop;
  logic              w_issue;
  logic              w_iss_eol;
  logic              w_iss_last;
  logic              w_out_eof;
  logic [PIX_W-1:0]  w_rdata;

  assign w_swap    = is_swap(r_mode);
  assign w_ox_last = w_swap ? H_LAST_X : W_LAST_X;
  assign w_oy_last = w_swap ? W_LAST_Y : H_LAST_Y;

  // Map the output coordinate back to its source pixel for the latched mode.
  always_comb begin
    w_sx = r_ox;
    w_sy = r_oy;
    unique case (r_mode)
      MODE_IDENT:   begin w_sx = r_ox;                   w_sy = r_oy;                   end
      MODE_ROT_CCW: begin w_sx = W_LAST_X - X_W'(r_oy);  w_sy = Y_W'(r_ox);             end
      MODE_ROT_CW:  begin w_sx = X_W'(r_oy);             w_sy = H_LAST_Y - Y_W'(r_ox);  end
      MODE_ROT180:  begin w_sx = W_LAST_X - r_ox;        w_sy = H_LAST_Y - r_oy;        end
      MODE_MIRR_H:  begin w_sx = W_LAST_X - r_ox;        w_sy = r_oy;                   end
      MODE_MIRR_V:  begin w_sx = r_ox;                   w_sy = H_LAST_Y - r_oy;        end
      MODE_TRANS:   begin w_sx = X_W'(r_oy);             w_sy = Y_W'(r_ox);             end
      MODE_ATRANS:  begin w_sx = W_LAST_X - X_W'(r_oy);  w_sy = H_LAST_Y - Y_W'(r_ox);  end
      default:      begin w_sx = r_ox;                   w_sy = r_oy;                   end
    endcase
  end

  assign w_rd_addr = ADDR_W'(w_sy) * W_A + ADDR_W'(w_sx);
  assign w_wr_addr = ADDR_W'(r_ly) * W_A + ADDR_W'(r_lx);

  assign w_start     = (r_state == ST_IDLE) && start;
  assign w_in_hs     = (r_state == ST_LOAD) && in_valid;
  assign w_load_last = w_in_hs && (r_lx == W_LAST_X) && (r_ly == H_LAST_Y);
  assign w_pop       = (r_cnt != 2'd0) && out_ready;
  assign w_out_eof   = (r_cnt != 2'd0) && r_buf_eof[r_rd_ptr];
  // A slot freed by this cycle's pop may be reused, which keeps 1 px/cycle.
  assign w_issue     = (r_state == ST_READ) && !r_iss_done &&
                       (({1'b0, r_cnt} + {2'b0, r_pend}) < (3'd2 + {2'b0, w_pop}));
  assign w_iss_eol   = (r_ox == w_ox_last);
  assign w_iss_last  = w_iss_eol && (r_oy == w_oy_last);
  assign w_addr      = (r_state == ST_LOAD) ? w_wr_addr : w_rd_addr;

  sram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (PIX_W)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_in_hs | w_issue),
    .i_we    (w_in_hs),
    .i_addr  (w_addr),
    .i_wdata (in_data),
    .o_rdata (w_rdata)
  );

  // Job FSM, latched configuration, stored-frame flag and done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_IDENT;
      r_frame_valid <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= (r_state == ST_READ) && w_pop && w_out_eof;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mode <= cfg_mode;
            if (cfg_reuse && r_frame_valid) begin
              r_state <= ST_READ;
            end else begin
              r_state       <= ST_LOAD;
              r_frame_valid <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (w_load_last) begin
            r_frame_valid <= 1'b1;
            r_state       <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_pop && w_out_eof) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Raster write counters for the incoming frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lx <= '0;
      r_ly <= '0;
    end else if (w_start) begin
      r_lx <= '0;
      r_ly <= '0;
    end else if (w_in_hs) begin
      if (r_lx == W_LAST_X) begin
        r_lx <= '0;
        r_ly <= (r_ly == H_LAST_Y) ? '0 : r_ly + 1'b1;
      end else begin
        r_lx <= r_lx + 1'b1;
      end
    end
  end

  // Output-coordinate scan; advances once per issued read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ox       <= '0;
      r_oy       <= '0;
      r_iss_done <= 1'b0;
    end else if (w_start) begin
      r_ox       <= '0;
      r_oy       <= '0;
      r_iss_done <= 1'b0;
    end else if (w_issue) begin
      if (w_iss_last) begin
        r_iss_done <= 1'b1;
      end else if (w_iss_eol) begin
        r_ox <= '0;
        r_oy <= r_oy + 1'b1;
      end else begin
        r_ox <= r_ox + 1'b1;
      end
    end
  end

  // Read-in-flight tracker plus the 2-entry output buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend     <= 1'b0;
      r_pend_eol <= 1'b0;
      r_pend_eof <= 1'b0;
      r_buf_data <= '{default: '0};
      r_buf_eol  <= '0;
      r_buf_eof  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_pend     <= w_issue;
      r_pend_eol <= w_iss_eol;
      r_pend_eof <= w_iss_last;
      if (r_pend) begin
        r_buf_data[r_wr_ptr] <= w_rdata;
        r_buf_eol[r_wr_ptr]  <= r_pend_eol;
        r_buf_eof[r_wr_ptr]  <= r_pend_eof;
        r_wr_ptr             <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
    end
  end

  assign in_ready  = (r_state == ST_LOAD);
  assign out_valid = (r_cnt != 2'd0);
  assign out_data  = out_valid ? r_buf_data[r_rd_ptr] : '0;
  assign out_eol   = out_valid && r_buf_eol[r_rd_ptr];
  assign out_eof   = w_out_eof;
  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_img_xform_engine.sv
// Bench for img_xform_engine on a 4x3 frame: constant first/last-line table,
// random frames and backpressure against a coordinate-mapping reference model,
// and an abort-by-reset sequence.
module tb_img_xform_engine;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] cfg_mode;
  logic       cfg_reuse;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_eol;
  logic       out_eof;
  logic       busy;
  logic       done;

  img_xform_engine #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_mode  (cfg_mode),
    .cfg_reuse (cfg_reuse),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_eol   (out_eol),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       eof;
  } pix_t;

  typedef struct packed {
    logic [2:0]      mode;
    logic            reuse;
    logic [2:0]      ow;
    logic [3:0][7:0] first;
    logic [3:0][7:0] last;
  } vec_t;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] frame [NPIX];
  pix_t       got_q [$];
  pix_t       exp_q [$];
  vec_t       tbl [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] m, input logic r, input int ow,
                              input int a0, input int a1, input int a2, input int a3,
                              input int b0, input int b1, input int b2, input int b3);
    vec_t v;
    v.mode = m;
    v.reuse = r;
    v.ow = 3'(ow);
    v.first[0] = 8'(a0); v.first[1] = 8'(a1); v.first[2] = 8'(a2); v.first[3] = 8'(a3);
    v.last[0]  = 8'(b0); v.last[1]  = 8'(b1); v.last[2]  = 8'(b2); v.last[3]  = 8'(b3);
    return v;
  endfunction

  // Reference: walk the output raster and fetch the source pixel the mode names.
  function automatic void build_exp(input logic [2:0] m);
    int   ow, oh, sx, sy;
    bit   sw;
    pix_t p;
    sw = (m == 3'd1) || (m == 3'd2) || (m == 3'd6) || (m == 3'd7);
    ow = sw ? H : W;
    oh = sw ? W : H;
    exp_q.delete();
    for (int oy = 0; oy < oh; oy++) begin
      for (int ox = 0; ox < ow; ox++) begin
        case (m)
          3'd0:    begin sx = ox;         sy = oy;         end
          3'd1:    begin sx = W - 1 - oy; sy = ox;         end
          3'd2:    begin sx = oy;         sy = H - 1 - ox; end
          3'd3:    begin sx = W - 1 - ox; sy = H - 1 - oy; end
          3'd4:    begin sx = W - 1 - ox; sy = oy;         end
          3'd5:    begin sx = ox;         sy = H - 1 - oy; end
          3'd6:    begin sx = oy;         sy = ox;         end
          default: begin sx = W - 1 - oy; sy = H - 1 - ox; end
        endcase
        p.d   = frame[sy * W + sx];
        p.eol = (ox == ow - 1);
        p.eof = (ox == ow - 1) && (oy == oh - 1);
        exp_q.push_back(p);
      end
    end
  endfunction

  // Starts a job in the current cycle and runs it to completion (or to
  // abort_after outputs), then compares the collected stream with the model.
  task automatic run_job(input logic [2:0] mode, input bit reuse, input bit exp_load,
                         input int pct, input int abort_after);
    int         pix = 0;
    int         first_valid = -1;
    int         bubbles = 0;
    int         stall_err = 0;
    int         done_early = 0;
    bit         seen_ready = 0;
    bit         stall_prev = 0;
    bit         finished = 0;
    bit         aborted = 0;
    logic [7:0] prev_data = '0;
    bit         hs_out, hs_in;
    pix_t       p;
    int         n;

    check("busy_before_start", busy, 1'b0);
    start     = 1'b1;
    cfg_mode  = mode;
    cfg_reuse = reuse;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("busy_after_start", busy, 1'b1);
    check("done_single_cycle", done, 1'b0);
    got_q.delete();
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (abort_after > 0 && got_q.size() == abort_after) begin
        aborted = 1;
        break;
      end
      if (in_ready) seen_ready = 1;
      if (done) done_early++;
      if (stall_prev && (!out_valid || out_data !== prev_data)) stall_err++;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (first_valid >= 0 && !out_valid) bubbles++;
      // Stray start/mode/in_valid activity while busy must be ignored.
      start    = 1'($urandom_range(0, 1));
      cfg_mode = 3'($urandom_range(0, 7));
      if (pix < NPIX) begin
        in_valid = ($urandom_range(0, 99) < pct);
        in_data  = frame[pix];
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      out_ready  = ($urandom_range(0, 99) < pct);
      hs_in      = in_valid && in_ready;
      hs_out     = out_valid && out_ready;
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      if (hs_out) begin
        p.d = out_data; p.eol = out_eol; p.eof = out_eof;
        got_q.push_back(p);
        if (out_eof) finished = 1;
      end
      if (hs_in) pix++;
      @(posedge clk); #1;
    end
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!aborted) begin
      check("job_complete", finished, 1'b1);
      check("done_pulse", done, 1'b1);
      check("busy_falls_with_done", busy, 1'b0);
      check("done_not_early", done_early, 0);
      check("load_phase_seen", seen_ready, exp_load);
      check("stall_data_stable", stall_err, 0);
      if (pct == 100) check("no_bubbles", bubbles, 0);
      if (pct == 100 && reuse && !exp_load) check("first_valid_latency", first_valid <= 2, 1'b1);
      build_exp(mode);
      check("out_count", got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        check("pix_data", got_q[i].d, exp_q[i].d);
        check("pix_eol_eof", {got_q[i].eol, got_q[i].eof}, {exp_q[i].eol, exp_q[i].eof});
      end
    end
  endtask

  initial begin
    int ow;
    int nd;
    tbl[0] = mk(3'd0, 1'b0, 4,  0,  1,  2,  3,   8,  9, 10, 11);
    tbl[1] = mk(3'd2, 1'b1, 3,  8,  4,  0,  0,  11,  7,  3,  0);
    tbl[2] = mk(3'd1, 1'b1, 3,  3,  7, 11,  0,   0,  4,  8,  0);
    tbl[3] = mk(3'd3, 1'b1, 4, 11, 10,  9,  8,   3,  2,  1,  0);
    tbl[4] = mk(3'd4, 1'b1, 4,  3,  2,  1,  0,  11, 10,  9,  8);
    tbl[5] = mk(3'd6, 1'b1, 3,  0,  4,  8,  0,   3,  7, 11,  0);
    tbl[6] = mk(3'd5, 1'b1, 4,  8,  9, 10, 11,   0,  1,  2,  3);
    tbl[7] = mk(3'd7, 1'b1, 3, 11,  7,  3,  0,   8,  4,  0,  0);
    for (int i = 0; i < NPIX; i++) frame[i] = 8'(i);

    rst = 1'b1; start = 1'b0; cfg_mode = '0; cfg_reuse = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {in_ready, out_valid, out_eol, out_eof, busy, done, out_data}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Back-to-back table jobs: each start lands in the previous job's done cycle.
    for (int i = 0; i < 8; i++) begin
      run_job(tbl[i].mode, tbl[i].reuse, (i == 0), 100, 0);
      ow = int'(tbl[i].ow);
      if (got_q.size() == NPIX) begin
        for (int j = 0; j < ow; j++) begin
          check("table_first_line", got_q[j].d, tbl[i].first[j]);
          check("table_last_line", got_q[NPIX - ow + j].d, tbl[i].last[j]);
        end
      end
    end

    // Mode 0 under 50% backpressure on the stored frame.
    run_job(3'd0, 1'b1, 1'b0, 50, 0);
    @(posedge clk); #1;
    check("done_cleared", done, 1'b0);

    // Random frames, modes and handshake gaps.
    for (int r = 0; r < 6; r++) begin
      bit         ru;
      logic [2:0] m;
      ru = (r % 2 == 1);
      m  = 3'($urandom_range(0, 7));
      if (!ru) for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom);
      run_job(m, ru, !ru, (r < 3) ? 50 : 100, 0);
    end

    // Abort mid-READ by reset after 5 outputs.
    for (int i = 0; i < NPIX; i++) frame[i] = 8'(i);
    run_job(3'd0, 1'b1, 1'b0, 100, 5);
    check("abort_output_count", got_q.size(), 5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_outputs_zero", {in_ready, out_valid, out_eol, out_eof, busy, done, out_data}, '0);
    rst = 1'b0;
    nd = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) nd++;
    end
    check("no_done_after_abort", nd, 0);
    // frame_valid was cleared, so a reuse request must reload.
    run_job(3'd0, 1'b1, 1'b1, 100, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
